// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests the word at PC, latches it for the decoder,
// then advances PC sequentially or by branch offset. Sticky fault on timeout or misalignment.
module fetch_unit #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        CLK,
  input  logic        Reset_L,
  input  logic [63:0] StartPC,
  output logic        IMemReq,
  output logic [63:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  output logic [31:0] Instr,
  output logic [25:0] Imm26,
  output logic        InstrValid,
  output logic [63:0] PC,
  input  logic [63:0] BusImm,
  input  logic        Branch,
  input  logic        Uncondbranch,
  input  logic        Zero,
  input  logic        Stall,
  output logic        Fault
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;
  localparam logic [1:0] FAULT = 2'd3;

  localparam int unsigned CntW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
  // Counter holds completed no-ack cycles; the cycle that would make it MAX_WAIT faults instead.
  localparam logic [CntW-1:0] LastCnt = CntW'(MAX_WAIT - 1);

  logic [1:0]      state_q, state_d;
  logic [63:0]     pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic        taken;
  logic [63:0] next_pc;

  assign taken   = Uncondbranch | (Branch & Zero);
  assign next_pc = taken ? (pc_q + BusImm) : (pc_q + 64'd4);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (IMemAck) begin
          instr_d = IMemData;
          cnt_d   = '0;
          state_d = ISSUE;
        end else if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          state_d = FAULT;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      ISSUE: begin
        if (!Stall) begin
          pc_d    = next_pc;
          state_d = (next_pc[1:0] != 2'b00) ? FAULT : FETCH;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      state_q <= IDLE;
      pc_q    <= StartPC;
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request is masked by reset so a stale FETCH state never drives the bus.
  assign IMemReq    = (state_q == FETCH) & Reset_L;
  assign IMemAddr   = pc_q;
  assign PC         = pc_q;
  assign Instr      = instr_q;
  assign Imm26      = instr_q[25:0];
  assign InstrValid = (state_q == ISSUE);
  assign Fault      = (state_q == FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations plus randomized traffic,
// all checked every cycle against a behavioural model of the fetch loop.
module tb_fetch_unit;

  localparam int unsigned MAX_WAIT = 15;

  logic        clk;
  logic        Reset_L;
  logic [63:0] StartPC;
  logic        IMemReq;
  logic [63:0] IMemAddr;
  logic        IMemAck;
  logic [31:0] IMemData;
  logic [31:0] Instr;
  logic [25:0] Imm26;
  logic        InstrValid;
  logic [63:0] PC;
  logic [63:0] BusImm;
  logic        Branch;
  logic        Uncondbranch;
  logic        Zero;
  logic        Stall;
  logic        Fault;

  fetch_unit #(.MAX_WAIT(MAX_WAIT)) dut (
    .CLK         (clk),
    .Reset_L     (Reset_L),
    .StartPC     (StartPC),
    .IMemReq     (IMemReq),
    .IMemAddr    (IMemAddr),
    .IMemAck     (IMemAck),
    .IMemData    (IMemData),
    .Instr       (Instr),
    .Imm26       (Imm26),
    .InstrValid  (InstrValid),
    .PC          (PC),
    .BusImm      (BusImm),
    .Branch      (Branch),
    .Uncondbranch(Uncondbranch),
    .Zero        (Zero),
    .Stall       (Stall),
    .Fault       (Fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: where the fetch loop is, expressed as "waiting for memory", "holding a word", "dead".
  bit          armed = 0;
  bit          m_booting;
  bit          m_waiting;
  bit          m_holding;
  bit          m_dead;
  int          m_misses;
  logic [63:0] m_pc;
  logic [31:0] m_instr;

  always @(posedge clk) begin
    logic [63:0] tgt;
    if (!Reset_L) begin
      armed     = 1;
      m_pc      = StartPC;
      m_instr   = 32'h0;
      m_booting = 1;
      m_waiting = 0;
      m_holding = 0;
      m_dead    = 0;
      m_misses  = 0;
    end else if (armed && !m_dead) begin
      if (m_booting) begin
        m_booting = 0;
        m_waiting = 1;
        m_misses  = 0;
      end else if (m_waiting) begin
        if (IMemAck) begin
          m_instr   = IMemData;
          m_waiting = 0;
          m_holding = 1;
          m_misses  = 0;
        end else begin
          m_misses++;
          if (m_misses >= MAX_WAIT) begin
            m_waiting = 0;
            m_dead    = 1;
          end
        end
      end else if (m_holding && !Stall) begin
        tgt       = (Uncondbranch || (Branch && Zero)) ? m_pc + BusImm : m_pc + 64'd4;
        m_pc      = tgt;
        m_holding = 0;
        if (tgt % 4 != 0) m_dead = 1;
        else m_waiting = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("req", {63'b0, IMemReq}, {63'b0, m_waiting && Reset_L});
      chk("addr", IMemAddr, m_pc);
      chk("pc", PC, m_pc);
      chk("instr", {32'b0, Instr}, {32'b0, m_instr});
      chk("imm26", {38'b0, Imm26}, {38'b0, m_instr[25:0]});
      chk("valid", {63'b0, InstrValid}, {63'b0, m_holding});
      chk("fault", {63'b0, Fault}, {63'b0, m_dead});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic quiet();
    Stall        = 1'b0;
    Branch       = 1'b0;
    Uncondbranch = 1'b0;
    Zero         = 1'b0;
    BusImm       = 64'h0;
  endtask

  // Leaves the DUT holding `data` fetched from `spc` (zero-wait memory).
  task automatic boot(input logic [63:0] spc, input logic [31:0] data);
    quiet();
    Reset_L  = 1'b0;
    StartPC  = spc;
    IMemAck  = 1'b1;
    IMemData = data;
    tick();
    Reset_L = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    int unsigned ack_pct;
    int unsigned pcts[4] = '{100, 70, 30, 5};

    Reset_L  = 1'b0;
    StartPC  = 64'h1000;
    IMemAck  = 1'b1;
    IMemData = 32'h8B020020;
    quiet();

    // Zero-wait sequential fetch from 0x1000
    tick();
    tick();
    chk("rst_pc", PC, 64'h1000);
    chk("rst_instr", {32'b0, Instr}, 64'h0);
    chk("rst_valid", {63'b0, InstrValid}, 64'h0);
    chk("rst_fault", {63'b0, Fault}, 64'h0);
    Reset_L = 1'b1;
    tick();
    chk("f1_req", {63'b0, IMemReq}, 64'h1);
    chk("f1_addr", IMemAddr, 64'h1000);
    chk("f1_valid", {63'b0, InstrValid}, 64'h0);
    tick();
    chk("lat_valid", {63'b0, InstrValid}, 64'h1);
    chk("lat_instr", {32'b0, Instr}, 64'h8B020020);
    chk("lat_imm26", {38'b0, Imm26}, 64'h3020020);
    tick();
    chk("f2_addr", IMemAddr, 64'h1004);
    tick();
    tick();
    chk("f3_addr", IMemAddr, 64'h1008);

    // Unconditional backward branch
    boot(64'h2000, 32'h14000000);
    Uncondbranch = 1'b1;
    BusImm       = 64'hFFFF_FFFF_FFFF_FFF0;
    tick();
    chk("ub_addr", IMemAddr, 64'h1FF0);

    // Conditional branch, not taken then taken
    boot(64'h3000, 32'hB4000200);
    Branch = 1'b1;
    BusImm = 64'h40;
    tick();
    chk("cbz_nt", IMemAddr, 64'h3004);
    boot(64'h3000, 32'hB4000200);
    Branch = 1'b1;
    Zero   = 1'b1;
    BusImm = 64'h40;
    tick();
    chk("cbz_t", IMemAddr, 64'h3040);

    // Stall holds everything; branch inputs during stall have no effect
    boot(64'h4000, 32'hB4000040);
    Stall        = 1'b1;
    Uncondbranch = 1'b1;
    Branch       = 1'b1;
    Zero         = 1'b1;
    BusImm       = 64'h100;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("st_instr", {32'b0, Instr}, 64'hB4000040);
      chk("st_pc", PC, 64'h4000);
      chk("st_valid", {63'b0, InstrValid}, 64'h1);
      chk("st_req", {63'b0, IMemReq}, 64'h0);
    end
    quiet();
    tick();
    chk("st_rel", IMemAddr, 64'h4004);

    // PC wraps modulo 2^64
    boot(64'hFFFF_FFFF_FFFF_FFFC, 32'h0);
    tick();
    chk("wrap", IMemAddr, 64'h0);

    // Misaligned reset vector is not checked
    boot(64'h5002, 32'h1);
    chk("mis_sp_valid", {63'b0, InstrValid}, 64'h1);
    chk("mis_sp_fault", {63'b0, Fault}, 64'h0);

    // Timeout: 15 unacknowledged fetch cycles
    quiet();
    Reset_L = 1'b0;
    StartPC = 64'h6000;
    IMemAck = 1'b0;
    tick();
    Reset_L = 1'b1;
    tick();
    for (int i = 0; i < MAX_WAIT - 1; i++) begin
      tick();
      chk("to_wait", {63'b0, Fault}, 64'h0);
    end
    tick();
    chk("to_fault", {63'b0, Fault}, 64'h1);
    chk("to_req", {63'b0, IMemReq}, 64'h0);
    Reset_L = 1'b0;
    tick();
    chk("to_clr", {63'b0, Fault}, 64'h0);
    chk("to_pc", PC, 64'h6000);
    Reset_L = 1'b1;
    IMemAck = 1'b1;
    tick();
    tick();
    Uncondbranch = 1'b1;
    BusImm       = 64'h2;
    tick();
    chk("mis_fault", {63'b0, Fault}, 64'h1);
    chk("mis_pc", PC, 64'h6002);

    // Reset during an in-flight fetch, ack in the same cycle
    quiet();
    Reset_L = 1'b0;
    StartPC = 64'h7000;
    IMemAck = 1'b0;
    tick();
    Reset_L = 1'b1;
    tick();
    tick();
    Reset_L  = 1'b0;
    IMemAck  = 1'b1;
    IMemData = 32'hDEADBEEF;
    tick();
    chk("rf_instr", {32'b0, Instr}, 64'h0);
    chk("rf_valid", {63'b0, InstrValid}, 64'h0);
    Reset_L = 1'b1;
    tick();
    chk("rf_addr", IMemAddr, 64'h7000);
    chk("rf_req", {63'b0, IMemReq}, 64'h1);

    // Randomized traffic
    ack_pct = 100;
    for (int i = 0; i < 4000; i++) begin
      if (i % 64 == 0) ack_pct = pcts[$urandom_range(3)];
      Reset_L = ($urandom_range(99) < 2) ? 1'b0 : 1'b1;
      if (!Reset_L) begin
        case ($urandom_range(7))
          0:       StartPC = 64'hFFFF_FFFF_FFFF_FFF0;
          1:       StartPC = {$urandom, $urandom};
          default: StartPC = {$urandom, $urandom} & ~64'h3;
        endcase
      end
      IMemAck      = ($urandom_range(99) < ack_pct);
      IMemData     = $urandom;
      Stall        = ($urandom_range(99) < 30);
      Branch       = 1'($urandom_range(1));
      Zero         = 1'($urandom_range(1));
      Uncondbranch = ($urandom_range(3) == 0);
      case ($urandom_range(15))
        0:       BusImm = {$urandom, $urandom};
        1, 2, 3: BusImm = {{48{1'b1}}, 16'($urandom)} & ~64'h3;
        default: BusImm = {$urandom, $urandom} & ~64'h3;
      endcase
      tick();
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
